// File: rtl/mem_responder_if.sv
// rtl/mem_responder_if.sv - cache-controller to memory handshake and beat bus
interface mem_responder_if #(
  parameter int ADDR_W = 24,
  parameter int DATA_W = 32,
  parameter int BEATS  = 4
);
  localparam int BW = $clog2(BEATS);

  logic              mem_read;
  logic              mem_write;
  logic [ADDR_W-1:0] address;
  logic [DATA_W-1:0] wdata;
  logic              wvalid;
  logic              wready;
  logic [DATA_W-1:0] rdata;
  logic              rvalid;
  logic [BW-1:0]     beat_idx;
  logic              mem_ready;
  logic              busy;
  logic              req_err;

  modport master (
    output mem_read, mem_write, address, wdata, wvalid,
    input  wready, rdata, rvalid, beat_idx, mem_ready, busy, req_err
  );

  modport slave (
    input  mem_read, mem_write, address, wdata, wvalid,
    output wready, rdata, rvalid, beat_idx, mem_ready, busy, req_err
  );
endinterface

// File: rtl/mem_responder.sv
// rtl/mem_responder.sv - line-burst memory model with access latency; MEM_STATS_EN adds rd/wr counters
module mem_responder #(
  parameter int ADDR_W  = 24,
  parameter int DATA_W  = 32,
  parameter int BEATS   = 4,
  parameter int LINES   = 256,
  parameter int LATENCY = 8
) (
  input  logic clk,
  input  logic rst,
  mem_responder_if.slave bus
`ifdef MEM_STATS_EN
  ,
  output logic [15:0] rd_count,
  output logic [15:0] wr_count
`endif
);
  localparam int BW = $clog2(BEATS);
  localparam int LW = $clog2(LINES);
  localparam int CW = $clog2(LATENCY + 1);

  typedef enum logic [2:0] {IDLE, WAIT, RBURST, WBURST, DONE} state_t;

  state_t            state, state_nxt;
  logic [CW-1:0]     lat_cnt;
  logic [BW-1:0]     beat;
  logic [LW-1:0]     line;
  logic              op_wr;
  logic              armed;
  logic [DATA_W-1:0] rdata_q;
  logic              rvalid_q;
  logic [BW-1:0]     rbeat_q;
  logic              mem_ready_q;
  logic              busy_q;
  logic              req_err_q;
  logic              req, accept, wr_fire, last_beat;
  logic              unused_addr;

  logic [DATA_W-1:0] mem [LINES*BEATS];

  always_comb begin
    state_nxt  = state;
    bus.wready = 1'b0;
    req        = bus.mem_read | bus.mem_write;
    accept     = (state == IDLE) && armed && req;
    wr_fire    = (state == WBURST) && bus.wvalid;
    last_beat  = (beat == BW'(BEATS - 1));
    case (state)
      IDLE:   if (accept) state_nxt = WAIT;
      WAIT:   if (lat_cnt == '0) state_nxt = op_wr ? WBURST : RBURST;
      RBURST: if (last_beat) state_nxt = DONE;
      WBURST: begin
        bus.wready = 1'b1;
        if (wr_fire && last_beat) state_nxt = DONE;
      end
      DONE:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Read data, rvalid, mem_ready and busy are registered, which places the
  // first beat LATENCY+1 cycles after the accepting edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      lat_cnt     <= '0;
      beat        <= '0;
      line        <= '0;
      op_wr       <= 1'b0;
      armed       <= 1'b1;
      rdata_q     <= '0;
      rvalid_q    <= 1'b0;
      rbeat_q     <= '0;
      mem_ready_q <= 1'b0;
      busy_q      <= 1'b0;
      req_err_q   <= 1'b0;
    end else begin
      state       <= state_nxt;
      busy_q      <= (state_nxt != IDLE);
      mem_ready_q <= (state == DONE);
      rvalid_q    <= (state == RBURST);
      if (state == RBURST) begin
        rdata_q <= mem[{line, beat}];
        rbeat_q <= beat;
      end else begin
        rbeat_q <= '0;
      end
      // A request still held across completion must drop once before re-arming.
      if (accept) begin
        line    <= bus.address[LW+5:6];
        op_wr   <= bus.mem_write;
        lat_cnt <= CW'(LATENCY - 1);
        armed   <= 1'b0;
        if (bus.mem_read && bus.mem_write) req_err_q <= 1'b1;
      end else if (state == IDLE && !req) begin
        armed <= 1'b1;
      end
      if (state == WAIT) begin
        beat <= '0;
        if (lat_cnt != '0) lat_cnt <= lat_cnt - CW'(1);
      end
      if (state == RBURST || wr_fire) beat <= beat + BW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (wr_fire) mem[{line, beat}] <= bus.wdata;
  end

`ifdef MEM_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_count <= '0;
      wr_count <= '0;
    end else if (state == DONE) begin
      if (op_wr) begin
        if (wr_count != 16'hFFFF) wr_count <= wr_count + 16'd1;
      end else begin
        if (rd_count != 16'hFFFF) rd_count <= rd_count + 16'd1;
      end
    end
  end
`endif

  assign unused_addr   = ^bus.address;
  assign bus.rdata     = rdata_q;
  assign bus.rvalid    = rvalid_q;
  assign bus.beat_idx  = (state == WBURST) ? beat : rbeat_q;
  assign bus.mem_ready = mem_ready_q;
  assign bus.busy      = busy_q;
  assign bus.req_err   = req_err_q;
endmodule

// File: tb/tb_mem_responder.sv
// tb/tb_mem_responder.sv - scoreboard bench for mem_responder against a line-array reference model
module tb_mem_responder;
  localparam int ADDR_W  = 24;
  localparam int DATA_W  = 32;
  localparam int BEATS   = 4;
  localparam int LINES   = 256;
  localparam int LATENCY = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   tests = 0;
  int   fails = 0;
  int   rd_n = 0;
  int   wr_n = 0;

  mem_responder_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .BEATS(BEATS)) bus ();

`ifdef MEM_STATS_EN
  logic [15:0] rd_count, wr_count;
`endif

  mem_responder #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .BEATS(BEATS), .LINES(LINES), .LATENCY(LATENCY)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
`ifdef MEM_STATS_EN
    ,
    .rd_count(rd_count),
    .wr_count(wr_count)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] data;
    int          beat;
    int          t;
  } rbeat_t;

  rbeat_t      rd_q[$];
  int          done_q[$];
  logic [31:0] model [LINES][BEATS];
  bit          written [LINES];
  int          wlines[$];

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  function automatic int line_of(input logic [23:0] addr);
    return int'(addr >> 6) % LINES;
  endfunction

  // Scoreboard monitor: every output beat and completion pulse is checked against the queues.
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.rvalid) begin
        if (rd_q.size() == 0) begin
          check("rvalid_unexpected", 1, 0);
        end else begin
          rbeat_t e;
          e = rd_q.pop_front();
          check("rdata", bus.rdata, e.data);
          check("r_beat_idx", bus.beat_idx, e.beat);
          check("r_beat_cycle", cyc, e.t);
        end
      end
      if (bus.mem_ready) begin
        if (done_q.size() == 0) begin
          check("mem_ready_unexpected", 1, 0);
        end else begin
          int t;
          t = done_q.pop_front();
          check("mem_ready_cycle", cyc, t);
          check("busy_at_ready", bus.busy, 0);
        end
      end
    end
  end

  task automatic start_req(input bit wr, input bit rd, input logic [23:0] addr, output int acc);
    int ln;
    @(negedge clk);
    bus.mem_read  = rd;
    bus.mem_write = wr;
    bus.address   = addr;
    bus.wvalid    = 1'b0;
    @(posedge clk);
    #1;
    acc = cyc;
    check("busy_after_accept", bus.busy, 1);
    ln = line_of(addr);
    if (!wr) begin
      for (int b = 0; b < BEATS; b++)
        rd_q.push_back('{model[ln][b], b, acc + LATENCY + 1 + b});
      done_q.push_back(acc + LATENCY + 1 + BEATS);
      rd_n++;
    end
  endtask

  task automatic finish_req(input bit hold);
    bit seen = 0;
    for (int i = 0; i < 400 && !seen; i++) begin
      @(negedge clk);
      seen = bus.mem_ready;
    end
    if (!seen) check("mem_ready_timeout", 0, 1);
    if (!hold) begin
      bus.mem_read  = 1'b0;
      bus.mem_write = 1'b0;
    end
  endtask

  task automatic do_read(input logic [23:0] addr, input bit hold, input bit drop_early);
    int acc;
    start_req(1'b0, 1'b1, addr, acc);
    if (drop_early) bus.mem_read = 1'b0;
    finish_req(hold);
  endtask

  task automatic do_write(input logic [23:0] addr, input logic [31:0] d [BEATS],
                          input int gaps [BEATS], input bit both, input bit drop_early);
    int acc, ln, n;
    ln = line_of(addr);
    start_req(1'b1, both, addr, acc);
    if (drop_early) begin
      bus.mem_read  = 1'b0;
      bus.mem_write = 1'b0;
    end
    for (int b = 0; b < BEATS; b++) begin
      n = 0;
      @(negedge clk);
      while (!bus.wready && n < 100) begin
        @(negedge clk);
        n++;
      end
      if (!bus.wready) begin
        check("wready_timeout", 0, 1);
        break;
      end
      for (int g = 0; g < gaps[b]; g++) begin
        check("wready_in_gap", bus.wready, 1);
        bus.wvalid = 1'b0;
        @(negedge clk);
      end
      check("w_beat_idx", bus.beat_idx, b);
      bus.wvalid = 1'b1;
      bus.wdata  = d[b];
      @(posedge clk);
      #1;
      bus.wvalid = 1'b0;
      model[ln][b] = d[b];
      if (b == BEATS - 1) begin
        done_q.push_back(cyc + 1);
        wr_n++;
      end
    end
    if (!written[ln]) begin
      written[ln] = 1'b1;
      wlines.push_back(ln);
    end
    finish_req(1'b0);
  endtask

  task automatic apply_reset(input bit check_regs);
    rst = 1'b1;
    bus.mem_read  = 1'b0;
    bus.mem_write = 1'b0;
    bus.wvalid    = 1'b0;
    #1;
    if (check_regs) begin
      check("rst_rvalid", bus.rvalid, 0);
      check("rst_rdata", bus.rdata, 0);
      check("rst_busy", bus.busy, 0);
      check("rst_mem_ready", bus.mem_ready, 0);
      check("rst_wready", bus.wready, 0);
      check("rst_beat_idx", bus.beat_idx, 0);
      check("rst_req_err", bus.req_err, 0);
    end
    rd_q.delete();
    done_q.delete();
    rd_n = 0;
    wr_n = 0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    logic [31:0] d [BEATS];
    int          gaps [BEATS];
    int          acc;
    bit          seen;
    logic [23:0] a;

    bus.mem_read  = 1'b0;
    bus.mem_write = 1'b0;
    bus.address   = '0;
    bus.wdata     = '0;
    bus.wvalid    = 1'b0;
    #1;
    apply_reset(1'b1);

    // Preload the line, then read it through an aliased byte offset.
    for (int b = 0; b < BEATS; b++) begin
      d[b] = 32'h1111_0000 + b;
      gaps[b] = 0;
    end
    do_write(24'hCA34C0, d, gaps, 1'b0, 1'b0);
    do_read(24'hCA34F2, 1'b0, 1'b0);
    @(negedge clk);
    check("busy_after_read", bus.busy, 0);

    // Gapped write-back: beat, idle, beat, beat, beat.
    for (int b = 0; b < BEATS; b++) d[b] = 32'hA0 + b;
    gaps = '{0, 1, 0, 0};
    do_write(24'hCA34C0, d, gaps, 1'b0, 1'b0);
    do_read(24'hCA34C0, 1'b0, 1'b0);

    // Request held high across completion must not re-execute.
    do_read(24'hCA34C0, 1'b1, 1'b0);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (i % 5 == 4) check("held_no_busy", bus.busy, 0);
    end
    bus.mem_read = 1'b0;
    do_read(24'h0A0040, 1'b0, 1'b0);

    // Simultaneous read+write: write wins, error is sticky.
    for (int b = 0; b < BEATS; b++) begin
      d[b] = 32'hB0B0_0000 + b;
      gaps[b] = 0;
    end
    do_write(24'h0A0040, d, gaps, 1'b1, 1'b0);
    check("req_err_set", bus.req_err, 1);
    do_read(24'h0A0040, 1'b0, 1'b0);
    check("req_err_sticky", bus.req_err, 1);

    // Randomised traffic over a small line pool with aliased upper bits.
    for (int k = 0; k < 16; k++) begin
      int ln;
      bit wr;
      wr = (wlines.size() == 0) || ($urandom_range(0, 1) == 1);
      if (wr) ln = $urandom_range(0, 5) * 37 % LINES;
      else    ln = wlines[$urandom_range(0, wlines.size() - 1)];
      a = 24'($urandom);
      a[13:6] = 8'(ln);
      if (wr) begin
        for (int b = 0; b < BEATS; b++) begin
          d[b] = $urandom;
          gaps[b] = $urandom_range(0, 2);
        end
        do_write(a, d, gaps, 1'b0, 1'($urandom_range(0, 1)));
      end else begin
        do_read(a, 1'b0, 1'($urandom_range(0, 1)));
      end
    end

`ifdef MEM_STATS_EN
    @(negedge clk);
    check("rd_count", rd_count, 16'(rd_n));
    check("wr_count", wr_count, 16'(wr_n));
`endif

    // Reset during read beat 2 aborts immediately.
    start_req(1'b0, 1'b1, 24'hCA34C0, acc);
    seen = 0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk);
      seen = bus.rvalid && (bus.beat_idx == 2);
    end
    if (!seen) check("beat2_timeout", 0, 1);
    #2;
    apply_reset(1'b1);
    do_read(24'hCA34C0, 1'b0, 1'b0);
    check("req_err_after_rst", bus.req_err, 0);

`ifdef MEM_STATS_EN
    for (int b = 0; b < BEATS; b++) gaps[b] = 0;
    do_read(24'hCA34C0, 1'b0, 1'b0);
    do_read(24'hCA34C0, 1'b0, 1'b0);
    do_write(24'h0A0040, d, gaps, 1'b0, 1'b0);
    do_write(24'h0A0040, d, gaps, 1'b0, 1'b0);
    @(negedge clk);
    check("rd_count_3", rd_count, 16'd3);
    check("wr_count_2", wr_count, 16'd2);
    force dut.rd_count = 16'hFFFF;
    @(negedge clk);
    release dut.rd_count;
    do_read(24'hCA34C0, 1'b0, 1'b0);
    @(negedge clk);
    check("rd_count_sat", rd_count, 16'hFFFF);
`endif

    repeat (5) @(negedge clk);
    check("rd_q_drained", rd_q.size(), 0);
    check("done_q_drained", done_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout got %0d expected finish", cyc);
    $fatal(1, "timeout");
  end
endmodule

// File: doc/mem_responder.md
Name: mem_responder

Overview:
- Main-memory side of the cache-controller/memory handshake.
- Accepts line-fill reads (mem_read) and dirty-line write-backs (mem_write) from the cache controller, and models access latency with a down-counter.
- Moves one cache line per request as a burst of beats, then signals completion with mem_ready.
- Backing store is an internal line-organised array; the block is used as the memory model in cache-controller simulations and as the FPGA memory stub.

Parameters:
- ADDR_W, 24, byte address width (tag 11 / index 7 / block offset 4 / word offset 2).
- DATA_W, 32, beat width in bits.
- BEATS, 4, beats per cache line; power of two, >=2.
- LINES, 256, lines in the backing store; power of two; indexed by the low log2(LINES) bits of the line address (address[ADDR_W-1:6]).
- LATENCY, 8, access cycles before the first beat; >=1.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- mem_read  in  1  line-fill request; level, held until mem_ready.
- mem_write  in  1  write-back request; level, held until mem_ready.
- address  in  ADDR_W  byte address; sampled on request accept; bits [5:0] ignored.
- wdata  in  DATA_W  write-back beat data.
- wvalid  in  1  wdata valid this cycle.
- wready  out  1  responder accepts a beat this cycle.
- rdata  out  DATA_W  fill beat data.
- rvalid  out  1  rdata valid this cycle.
- beat_idx  out  log2(BEATS)  index of the current rdata beat / next accepted wdata beat.
- mem_ready  out  1  one-cycle completion pulse.
- busy  out  1  a transaction is in progress.
- req_err  out  1  sticky: mem_read and mem_write were seen together in IDLE.

Behaviour:
- Reset: all outputs 0, FSM to IDLE, counters 0, stored line address 0. Array contents are not reset.
- Reset mid-transaction aborts immediately. No partial-line commit guarantee: beats already written stay written.
- States: IDLE, WAIT, RBURST, WBURST, DONE.
- IDLE:
  - On mem_read or mem_write: latch line address and op, load the latency counter with LATENCY-1, busy=1, go to WAIT.
  - Both asserted: write wins and req_err is set; req_err clears only on rst.
- WAIT:
  - Counter decrements each cycle.
  - At 0: go to RBURST (read) or WBURST (write), beat counter = 0.
  - First read beat appears exactly LATENCY+1 cycles after the accepting edge.
- RBURST:
  - rvalid=1 every cycle; rdata = array[line][beat_idx]; beat_idx increments 0..BEATS-1.
  - No backpressure.
  - After the last beat: go to DONE.
- WBURST:
  - wready=1.
  - Each cycle with wvalid=1 writes wdata to array[line][beat_idx] and increments beat_idx.
  - wvalid=0 stalls indefinitely.
  - After beat BEATS-1 is accepted: go to DONE.
- DONE:
  - mem_ready=1 for exactly one cycle; busy drops in the same cycle.
  - Next state is IDLE.
- IDLE re-entry guard: a new request is accepted only after both mem_read and mem_write have been sampled low at least once since the mem_ready pulse. A request held high across DONE is not re-executed.
- Request dropped during WAIT/RBURST/WBURST: ignored; the transaction completes normally.
- beat_idx wraps BEATS-1 -> 0 only through a state change; no overflow past BEATS.
- Line index arithmetic is modulo LINES; address bits above the index are ignored (aliasing).

Optional Feature:
- MEM_STATS_EN defined:
  - Adds outputs rd_count[15:0] and wr_count[15:0].
  - Each increments on the mem_ready pulse of a completed read/write.
  - Each saturates at 16'hFFFF and resets to 0 on rst.
- Undefined: the ports and counters do not exist; behaviour is otherwise identical.

Test Plan:
- Read (LATENCY=8), address 24'hCA34F2, line preloaded with 32'h1111_0000..32'h1111_0003 -> rvalid first high 9 cycles after accept; beats 0..3 in order; mem_ready pulses one cycle after beat 3; busy low thereafter.
- Write-back, address 24'hCA34C0, wvalid gapped (beat, idle, beat, beat, beat) with data A0..A3 -> wready high throughout WBURST; 4 beats stored; mem_ready once; a following read of the same line returns A0..A3.
- mem_read held high for 20 cycles after mem_ready -> no second transaction; dropping and re-raising mem_read starts a new read.
- mem_read and mem_write raised together in IDLE -> write executed, req_err=1 and stays 1 until rst.
- rst asserted during RBURST beat 2 -> all outputs 0 asynchronously; next read behaves normally from IDLE.
- With MEM_STATS_EN: 3 reads and 2 writes -> rd_count=3, wr_count=2; force rd_count to 16'hFFFF, complete one read -> stays 16'hFFFF.
